serial_word_loader: RTL and testbench
=====================================

Name: serial_word_loader

Overview:
- Upstream feeder for the 4-bit load/reset register. Receives a framed serial bit stream and assembles it into a parallel word.
- Drives the register's data input from D_OUT and its load strobe from L_OUT. L_OUT pulses for one cycle per good frame.
- Bits are sampled only on cycles where the bit-strobe EN is high, so the block runs at any bit rate below CLK.

Parameters:
- WIDTH, 4, data bits per frame; matches the downstream register width.
- PAR_EN, 0, 1 = an even-parity bit follows the data bits; 0 = no parity bit.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- R  input  1  reset, asynchronous, active-low (0 = reset).
- SIN  input  1  serial data; idles high.
- EN  input  1  bit-sample strobe; SIN is sampled only on edges where EN=1.
- D_OUT  output  WIDTH  last good word; held between loads.
- L_OUT  output  1  one-cycle load pulse for the downstream register.
- BUSY  output  1  high while a frame is in progress (state != IDLE).
- ERR  output  1  one-cycle pulse on a framing or parity error.

Behaviour:
- Frame format, LSB first: start bit (0), WIDTH data bits, parity bit (only if PAR_EN=1), stop bit (1).
- Reset (R=0), applied asynchronously:
  - state=IDLE, bit counter=0, shift register=0.
  - D_OUT=0, L_OUT=0, ERR=0, BUSY=0.
  - Reset during a frame aborts it; no L_OUT and no ERR are produced.
- EN=0 cycles: state, counter and shift register hold. L_OUT and ERR return to 0 (they are pulses only).
- IDLE:
  - EN=1 and SIN=0 -> DATA, counter=0.
  - EN=1 and SIN=1 -> stay in IDLE.
- DATA:
  - Each EN=1 edge writes SIN into shift register bit [counter], then counter increments.
  - On the WIDTH-th sample -> PARITY if PAR_EN=1, else STOP.
- PARITY:
  - On EN=1, sample SIN and set par_err = (XOR of data bits) XOR SIN. Even parity means total ones including the parity bit is even.
  - Then -> STOP.
- STOP: on EN=1:
  - If SIN=1 and par_err=0: D_OUT <= shift register, L_OUT=1.
  - Otherwise: ERR=1, D_OUT unchanged.
  - In both cases -> IDLE and par_err is cleared.
- Latency: L_OUT or ERR is high for exactly the one cycle following the edge that sampled the stop bit. D_OUT is valid in that same cycle and stays until the next good frame.
- L_OUT and ERR are never high together. At most one of them fires per frame.
- Back-to-back frames: a start bit on the very next EN strobe after the stop sample is accepted. No idle gap is required.
- The start bit is not re-validated: a single EN sample of 0 in IDLE starts a frame.
- BUSY is derived from the state register. It goes high in the cycle after start detection and low in the cycle after the stop sample.
- All outputs are registered except BUSY, which is decoded directly from the state register.

Test Plan:
- PAR_EN=0, EN=1 every cycle, SIN=0,0,1,0,1,1 -> D_OUT=4'hA; L_OUT high for exactly 1 cycle after the stop-bit edge; ERR=0; BUSY high for 5 cycles.
- Following frame SIN=0,1,1,1,1,0 (stop bit 0) -> ERR pulses for 1 cycle; L_OUT stays 0; D_OUT remains 4'hA.
- EN every 4th cycle, frame for 4'h5 (0,1,0,1,0,1), SIN toggled on non-strobe cycles -> D_OUT=4'h5 with one L_OUT pulse; the toggles are ignored.
- PAR_EN=1, data 4'h7 (bits 1,1,1,0), parity bit 1, stop 1 -> D_OUT=4'h7 with L_OUT pulse. Same frame with parity bit 0 -> ERR pulse; D_OUT unchanged.
- R driven low after 2 data bits -> BUSY, L_OUT, ERR and D_OUT go to 0 without waiting for a clock edge. After R returns high, frame for 4'h3 -> D_OUT=4'h3 with one L_OUT pulse.
- Two back-to-back frames 4'h9 then 4'h6, with the second start bit on the strobe right after the first stop -> two L_OUT pulses; D_OUT=4'h9, then 4'h6; ERR=0 throughout.

Source files
------------

// File: rtl/serial_word_loader.sv
// Framed serial-to-parallel loader feeding the 4-bit load/reset register.
// Samples SIN on EN strobes and emits a one-cycle load pulse per good frame.
module serial_word_loader #(
    parameter int WIDTH  = 4,
    parameter int PAR_EN = 0
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             SIN,
    input  logic             EN,
    output logic [WIDTH-1:0] D_OUT,
    output logic             L_OUT,
    output logic             BUSY,
    output logic             ERR
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   cnt_s;
    logic [WIDTH-1:0]   shift_r;
    logic [WIDTH-1:0]   shift_s;
    logic               par_err_r;
    logic               par_err_s;
    logic [WIDTH-1:0]   d_out_r;
    logic [WIDTH-1:0]   d_out_s;
    logic               l_out_r;
    logic               l_out_s;
    logic               err_r;
    logic               err_s;

    // Nonzero when data plus the received parity bit holds an odd number of ones.
    function automatic logic even_parity_err(input logic [WIDTH-1:0] data,
                                             input logic             pbit);
        return (^data) ^ pbit;
    endfunction

    // State, counter, shift register and registered outputs.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {IDX_W{1'b0}};
            shift_r   <= {WIDTH{1'b0}};
            par_err_r <= 1'b0;
            d_out_r   <= {WIDTH{1'b0}};
            l_out_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            shift_r   <= shift_s;
            par_err_r <= par_err_s;
            d_out_r   <= d_out_s;
            l_out_r   <= l_out_s;
            err_r     <= err_s;
        end
    end

    // Next-state and output decode; pulses default low so EN=0 cycles clear them.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        shift_s   = shift_r;
        par_err_s = par_err_r;
        d_out_s   = d_out_r;
        l_out_s   = 1'b0;
        err_s     = 1'b0;
        if (EN) begin
            case (state_r)
                ST_IDLE: begin
                    if (!SIN) begin
                        state_s = ST_DATA;
                        cnt_s   = {IDX_W{1'b0}};
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_s[cnt_r] = SIN;
                    cnt_s          = cnt_r + IDX_W'(1);
                    if (cnt_r == LAST_IDX) begin
                        if (PAR_EN != 0) begin
                            state_s = ST_PARITY;
                        end else begin
                            state_s = ST_STOP;
                        end
                    end else begin
                        state_s = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    par_err_s = even_parity_err(shift_r, SIN);
                    state_s   = ST_STOP;
                end
                ST_STOP: begin
                    if (SIN && !par_err_r) begin
                        d_out_s = shift_r;
                        l_out_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                    par_err_s = 1'b0;
                    state_s   = ST_IDLE;
                end
                default: begin
                    state_s   = ST_IDLE;
                    par_err_s = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    assign D_OUT = d_out_r;
    assign L_OUT = l_out_r;
    assign ERR   = err_r;
    assign BUSY  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_serial_word_loader.sv
// Bench for serial_word_loader: one instance without parity, one with even parity,
// both checked every cycle against a frame-level reference model.
module tb_serial_word_loader;

    logic       clk;
    logic       r;
    logic       sin0, en0, sin1, en1;
    logic [3:0] d_out0, d_out1;
    logic       l_out0, l_out1, busy0, busy1, err0, err1;

    int errors = 0;
    int checks = 0;

    // Reference model: bits collected since the start bit, judged once the frame is complete.
    logic       m_act [2];
    int         m_len [2];
    logic [7:0] m_frm [2];
    logic [3:0] exp_d [2];
    logic       exp_l [2];
    logic       exp_e [2];

    serial_word_loader #(.WIDTH(4), .PAR_EN(0)) u_nopar (
        .CLK(clk), .R(r), .SIN(sin0), .EN(en0),
        .D_OUT(d_out0), .L_OUT(l_out0), .BUSY(busy0), .ERR(err0)
    );

    serial_word_loader #(.WIDTH(4), .PAR_EN(1)) u_par (
        .CLK(clk), .R(r), .SIN(sin1), .EN(en1),
        .D_OUT(d_out1), .L_OUT(l_out1), .BUSY(busy1), .ERR(err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0;
            m_len[i] = 0;
            m_frm[i] = 8'h00;
            exp_d[i] = 4'h0;
            exp_l[i] = 1'b0;
            exp_e[i] = 1'b0;
        end
    endtask

    task automatic model_bit(input int d, input logic s, input logic e);
        int         flen;
        logic [7:0] f;
        logic [3:0] data;
        logic       ok;
        flen     = (d == 1) ? 7 : 6;
        exp_l[d] = 1'b0;
        exp_e[d] = 1'b0;
        if (e) begin
            if (!m_act[d]) begin
                if (s == 1'b0) begin
                    m_act[d] = 1'b1;
                    m_frm[d] = 8'h00;
                    m_len[d] = 1;
                end
            end else begin
                m_frm[d][m_len[d]] = s;
                m_len[d]++;
                if (m_len[d] == flen) begin
                    f    = m_frm[d];
                    data = f[4:1];
                    ok   = (f[flen-1] == 1'b1);
                    if (d == 1 && (($countones(data) + int'(f[5])) % 2) != 0) ok = 1'b0;
                    if (ok) begin
                        exp_d[d] = data;
                        exp_l[d] = 1'b1;
                    end else begin
                        exp_e[d] = 1'b1;
                    end
                    m_act[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("nopar_dout", 32'(d_out0), 32'(exp_d[0]));
        chk("nopar_load", 32'(l_out0), 32'(exp_l[0]));
        chk("nopar_err",  32'(err0),   32'(exp_e[0]));
        chk("nopar_busy", 32'(busy0),  32'(m_act[0]));
        chk("par_dout",   32'(d_out1), 32'(exp_d[1]));
        chk("par_load",   32'(l_out1), 32'(exp_l[1]));
        chk("par_err",    32'(err1),   32'(exp_e[1]));
        chk("par_busy",   32'(busy1),  32'(m_act[1]));
    endtask

    // One clock cycle on instance d; the other instance sees no strobe.
    task automatic step(input int d, input logic s, input logic e);
        if (d == 0) begin
            sin0 = s; en0 = e; en1 = 1'b0;
        end else begin
            sin1 = s; en1 = e; en0 = 1'b0;
        end
        @(posedge clk);
        model_bit(0, sin0, en0);
        model_bit(1, sin1, en1);
        @(negedge clk);
        check_all();
    endtask

    // Full frame; gap = cycles per strobe, non-strobe cycles carry random SIN.
    task automatic frame(input int d, input logic [3:0] data, input logic pbit,
                         input logic stop, input int gap);
        logic [7:0] bits;
        int         n;
        bits = 8'h00;
        bits[4:1] = data;
        if (d == 1) begin
            bits[5] = pbit;
            bits[6] = stop;
            n = 7;
        end else begin
            bits[5] = stop;
            n = 6;
        end
        for (int i = 0; i < n; i++) begin
            for (int g = 1; g < gap; g++) step(d, 1'($urandom_range(0, 1)), 1'b0);
            step(d, bits[i], 1'b1);
        end
    endtask

    initial begin
        logic [3:0] rd;
        int         dd;
        r = 1'b0; sin0 = 1'b1; sin1 = 1'b1; en0 = 1'b0; en1 = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        r = 1'b1;
        step(0, 1'b1, 1'b1);

        // Basic frame, then a frame with a bad stop bit
        frame(0, 4'hA, 1'b0, 1'b1, 1);
        chk("p1_dout", 32'(d_out0), 32'h0000000A);
        frame(0, 4'hF, 1'b0, 1'b0, 1);
        chk("p2_dout_held", 32'(d_out0), 32'h0000000A);
        step(0, 1'b1, 1'b1);

        // Sparse strobe with toggling SIN between strobes
        frame(0, 4'h5, 1'b0, 1'b1, 4);
        chk("p3_dout", 32'(d_out0), 32'h00000005);

        // Even parity: good then bad parity bit
        frame(1, 4'h7, 1'b1, 1'b1, 1);
        chk("p4_dout", 32'(d_out1), 32'h00000007);
        frame(1, 4'h7, 1'b0, 1'b1, 1);
        chk("p4_dout_held", 32'(d_out1), 32'h00000007);

        // Asynchronous reset in the middle of a frame
        step(0, 1'b0, 1'b1);
        step(0, 1'b1, 1'b1);
        step(0, 1'b1, 1'b1);
        #2;
        r = 1'b0;
        #1;
        model_reset();
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_dout", 32'(d_out0), 32'h0);
        chk("rst_load", 32'(l_out0), 32'h0);
        chk("rst_err",  32'(err0),   32'h0);
        check_all();
        @(negedge clk);
        r = 1'b1;
        frame(0, 4'h3, 1'b0, 1'b1, 1);
        chk("p5_dout", 32'(d_out0), 32'h00000003);

        // Back-to-back frames with no idle gap
        frame(0, 4'h9, 1'b0, 1'b1, 1);
        chk("p6_first", 32'(d_out0), 32'h00000009);
        frame(0, 4'h6, 1'b0, 1'b1, 1);
        chk("p6_second", 32'(d_out0), 32'h00000006);
        step(0, 1'b1, 1'b1);
        step(1, 1'b1, 1'b1);

        // Randomized frames, including bad stop and parity bits
        for (int k = 0; k < 40; k++) begin
            dd = int'($urandom_range(0, 1));
            rd = 4'($urandom);
            frame(dd, rd, (^rd) ^ ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) != 0),
                  int'($urandom_range(1, 3)));
            if ($urandom_range(0, 1) == 1) step(dd, 1'b1, 1'b1);
        end

        // Free-running random bit stream and strobe
        for (int k = 0; k < 600; k++) begin
            step(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
